// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory stall responder
package dmem_pkg;

    localparam int LAT_W  = 4;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_word_array.sv
// rtl/dmem_word_array.sv - word storage: synchronous write, combinational read, async clear
module dmem_word_array
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Reset clears every word so a dropped or committed store never survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_stall_responder.sv
// rtl/dmem_stall_responder.sv - multi-cycle data-memory responder with pipeline stall
// Optional misalign error reporting is enabled by defining DMEM_MISALIGN_ERR_EN.
module dmem_stall_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 6,
    parameter int LAT       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              stall,
    output logic              done,
    output logic [WORD_W-1:0] rdata,
    output logic              err
);

    dmem_state_t          state_q, state_d;
    logic [LAT_W-1:0]     cnt_q, cnt_d;
    logic                 wr_q, wr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [WORD_W-1:0]    wdata_q, wdata_d;
    logic                 mis_q, mis_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [WORD_W-1:0]    rdata_q, rdata_d;

    logic                 mem_we;
    logic [WORD_W-1:0]    mem_rdata;
    logic                 req_mis;
    logic                 unused_addr_bits;

`ifdef DMEM_MISALIGN_ERR_EN
    assign req_mis = |req_addr[1:0];
`else
    assign req_mis = 1'b0;
`endif

    // Bits above the word index wrap; byte-lane bits only matter for the misalign check.
    assign unused_addr_bits = ^{req_addr[31:ADDR_BITS+2], req_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        mem_we  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr[ADDR_BITS+1:2];
                    wdata_d = req_wdata;
                    mis_d   = req_mis;
                    cnt_d   = LAT_W'(LAT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    mem_we  = wr_q & ~mis_q;
                    if (!wr_q && !mis_q) begin
                        rdata_d = mem_rdata;
                    end
                    done_d  = 1'b1;
                    err_d   = mis_q;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                // The request still visible here is the retiring one; never re-accept it.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    dmem_word_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_word_array (
        .clk   (clk),
        .rst_n (reset),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign stall = req_valid & ~done_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_stall_responder.sv
// tb/tb_dmem_stall_responder.sv - scoreboard bench for dmem_stall_responder
module tb_dmem_stall_responder;

    localparam int ADDR_BITS = 6;
    localparam int LAT       = 2;
    localparam int DEPTH     = 2 ** ADDR_BITS;

`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    always #5 clk = ~clk;

    dmem_stall_responder #(
        .ADDR_BITS (ADDR_BITS),
        .LAT       (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .err       (err)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_rdata;
    int          checks = 0;
    int          errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic predict(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        logic mis;
        int   idx;
        mis = MIS_EN && (addr[1:0] != 2'b00);
        idx = int'(addr[ADDR_BITS+1:2]);
        if (wr && !mis) model[idx] = wdata;
        if (!wr && !mis) last_rdata = model[idx];
        e.rdata = last_rdata;
        e.err   = mis;
        sb_q.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_rdata"}, rdata, e.rdata);
            check_eq({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
        end
    endtask

    // mode 0: plain; mode 1: drop req_valid in WAIT; mode 2: scramble fields in WAIT
    task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int mode);
        int   cyc;
        logic seen;
        predict(wr, addr, wdata);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                check_eq({tag, "_stall_wait"}, {31'd0, stall}, {31'd0, req_valid});
                if (mode == 1) req_valid = 1'b0;
                if (mode == 2) begin
                    req_addr  = addr ^ 32'h0000_0004;
                    req_wdata = ~wdata;
                    req_write = ~wr;
                end
            end
            if (done) begin
                seen = 1'b1;
                check_eq({tag, "_latency"}, cyc, LAT + 1);
                check_eq({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
                pop_compare(tag);
            end
        end
        if (!seen) check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic apply_reset_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        last_rdata = 32'd0;
        sb_q.delete();
    endtask

    initial begin
        int done_cnt;
        int last_done;
        logic        r_wr;
        logic [31:0] r_addr;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        apply_reset_model();
        #1;
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        access("st_10", 1'b1, 32'h10, 32'hDEAD_BEEF, 0);
        access("ld_10", 1'b0, 32'h10, 32'h0, 0);
        access("st_14", 1'b1, 32'h14, 32'h0000_5A5A, 0);
        access("ld_14", 1'b0, 32'h14, 32'h0, 0);
        access("ld_13", 1'b0, 32'h13, 32'h0, 0);
        access("st_13", 1'b1, 32'h13, 32'h0000_0077, 0);
        access("ld_10b", 1'b0, 32'h10, 32'h0, 0);

        // Back-to-back: req_valid held across two loads.
        predict(1'b0, 32'h14, 32'h0);
        predict(1'b0, 32'h10, 32'h0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h14;
        done_cnt  = 0;
        last_done = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                last_done = i;
                pop_compare("b2b");
                if (done_cnt == 1) req_addr = 32'h10;
                if (done_cnt == 2) req_valid = 1'b0;
            end
        end
        check_eq("b2b_count", done_cnt, 2);
        check_eq("b2b_last", last_done, 2 * (LAT + 2) - 1);

        access("st_wrap", 1'b1, 32'h100, 32'h0000_1234, 0);
        access("ld_wrap", 1'b0, 32'h000, 32'h0, 0);
        access("st_drop", 1'b1, 32'h08, 32'h0000_CAFE, 1);
        access("ld_drop", 1'b0, 32'h08, 32'h0, 0);
        access("st_scr", 1'b1, 32'h18, 32'h0000_0011, 2);
        access("ld_scr", 1'b0, 32'h18, 32'h0, 0);
        access("ld_scr1c", 1'b0, 32'h1C, 32'h0, 0);

        // Reset in the middle of a store's WAIT phase.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_eq("midrst_stall", {31'd0, stall}, 32'd1);
        check_eq("midrst_done", {31'd0, done}, 32'd0);
        check_eq("midrst_rdata", rdata, 32'd0);
        check_eq("midrst_err", {31'd0, err}, 32'd0);
        apply_reset_model();
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        access("ld_20", 1'b0, 32'h20, 32'h0, 0);
        access("ld_00", 1'b0, 32'h00, 32'h0, 0);

        for (int n = 0; n < 16; n++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = 32'($urandom_range(0, 511));
            access("rnd", r_wr, r_addr, $urandom, 0);
        end

        check_eq("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
